rr_lease_arbiter: RTL and testbench

- Four-requester, first-come-first-served arbiter with a bounded grant lease for one shared resource.
- Each new request (rising edge) is queued in arrival order.
- The head of the queue is granted for at most HOLD_MAX cycles. The grant is then revoked, or released earlier if the requester drops its request.
- Sits between the request/grant handshake of the requesting units and the shared resource, replacing a fixed-priority grant.

---
 rtl/rr_lease_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rr_lease_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_lease_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_lease_arbiter: four-way first-come-first-served arbiter with a    |
// | bounded grant lease. Revision 1.0                                    |
// +----------------------------------------------------------------------+
module rr_lease_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int TIMER_W  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request1,
  input  logic       request2,
  input  logic       request3,
  input  logic       request4,
  output logic [3:0] grant_o,
  output logic       expire_o,
  output logic [2:0] qcount_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(HOLD_MAX - 1);

  // Internal id k (0..3) stands for requester k+1.
  logic [3:0]         w_req;
  logic [3:0]         w_rise;
  logic [3:0]         w_cand;
  logic               w_push;
  logic [1:0]         w_push_id;
  logic [3:0]         w_push_oh;
  logic               w_pop;
  logic [1:0]         w_head_id;
  logic [1:0]         w_tail;
  logic [2:0]         w_count_nxt;
  state_t             w_state_nxt;
  logic [3:0]         w_grant_nxt;
  logic               w_expire_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [1:0]         w_owner_nxt;

  logic [3:0]         r_req_q;
  logic [3:0]         r_pend;
  logic [1:0]         r_fifo [4];
  logic [1:0]         r_head;
  logic [2:0]         r_count;
  state_t             r_state;
  logic [1:0]         r_owner;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_grant;
  logic               r_expire;
  logic               r_busy;

  assign w_req     = {request4, request3, request2, request1};
  assign w_rise    = w_req & ~r_req_q;
  assign w_cand    = r_pend & w_req;
  assign w_head_id = r_fifo[r_head];
  assign w_tail    = r_head + r_count[1:0];
  assign w_push_oh = w_push ? (4'b0001 << w_push_id) : 4'b0000;

  // Lowest pending id wins the single push slot; a full queue defers it.
  always_comb begin
    w_push    = 1'b0;
    w_push_id = 2'd0;
    if (r_count != 3'd4) begin
      for (int i = 3; i >= 0; i--) begin
        if (w_cand[i]) begin
          w_push    = 1'b1;
          w_push_id = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_grant_nxt  = r_grant;
    w_expire_nxt = 1'b0;
    w_timer_nxt  = r_timer;
    w_owner_nxt  = r_owner;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = 4'b0000;
        if (r_count != 3'd0) begin
          w_pop = 1'b1;
          // A head whose requester has already gone is silently discarded.
          if (w_req[w_head_id]) begin
            w_state_nxt = ST_GRANT;
            w_owner_nxt = w_head_id;
            w_grant_nxt = 4'b1000 >> w_head_id;
            w_timer_nxt = '0;
          end
        end
      end
      ST_GRANT: begin
        if (!w_req[r_owner]) begin
          w_grant_nxt = 4'b0000;
          w_state_nxt = ST_RELEASE;
        end else if (r_timer == C_TIMER_LAST) begin
          w_grant_nxt  = 4'b0000;
          w_expire_nxt = 1'b1;
          w_state_nxt  = ST_RELEASE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_grant_nxt = 4'b0000;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_q  <= 4'b0000;
      r_pend   <= 4'b0000;
      r_head   <= 2'd0;
      r_count  <= 3'd0;
      r_state  <= ST_IDLE;
      r_owner  <= 2'd0;
      r_timer  <= '0;
      r_grant  <= 4'b0000;
      r_expire <= 1'b0;
      r_busy   <= 1'b0;
      for (int i = 0; i < 4; i++) r_fifo[i] <= 2'd0;
    end else begin
      r_req_q  <= w_req;
      r_pend   <= w_rise | (r_pend & w_req & ~w_push_oh);
      r_count  <= w_count_nxt;
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_timer  <= w_timer_nxt;
      r_grant  <= w_grant_nxt;
      r_expire <= w_expire_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE) || (w_count_nxt != 3'd0);
      if (w_pop) r_head <= r_head + 2'd1;
      if (w_push) r_fifo[w_tail] <= w_push_id;
    end
  end

  assign grant_o  = r_grant;
  assign expire_o = r_expire;
  assign qcount_o = r_count;
  assign busy_o   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rr_lease_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_lease_arbiter: directed and random stimulus against a queue-   |
// | based reference model. Revision 1.0                                  |
// +----------------------------------------------------------------------+
module tb_rr_lease_arbiter;

  localparam int HOLD = 4;

  logic       clock;
  logic       reset;
  logic [3:0] req_drv;   // bit k drives requester k+1
  logic [3:0] grant_o;
  logic       expire_o;
  logic [2:0] qcount_o;
  logic       busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  rr_lease_arbiter #(.HOLD_MAX(HOLD), .TIMER_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .request1 (req_drv[0]),
    .request2 (req_drv[1]),
    .request3 (req_drv[2]),
    .request4 (req_drv[3]),
    .grant_o  (grant_o),
    .expire_o (expire_o),
    .qcount_o (qcount_o),
    .busy_o   (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: arrival queue of ids, pending flags, owner and lease age.
  int m_q[$];
  bit m_pend [4];
  bit m_prev [4];
  int m_owner;
  int m_phase;     // 0 idle, 1 granted, 2 release guard
  int m_held;      // cycles the current grant has been visible
  bit m_expire;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_step(input logic [3:0] req, input logic rst);
    bit rise [4];
    int old_size;
    int pushed;
    int h;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
      end
      m_owner = 0; m_phase = 0; m_held = 0; m_expire = 0;
      return;
    end
    old_size = m_q.size();
    for (int i = 0; i < 4; i++) rise[i] = req[i] && !m_prev[i];
    pushed = -1;
    if (old_size < 4)
      for (int i = 0; i < 4; i++)
        if (pushed < 0 && m_pend[i] && req[i]) pushed = i;
    m_expire = 0;
    case (m_phase)
      0: if (old_size > 0) begin
           h = m_q.pop_front();
           if (req[h]) begin
             m_owner = h; m_held = 1; m_phase = 1;
           end
         end
      1: if (!req[m_owner]) m_phase = 2;
         else if (m_held == HOLD) begin m_phase = 2; m_expire = 1; end
         else m_held++;
      default: m_phase = 0;
    endcase
    if (pushed >= 0) m_q.push_back(pushed);
    for (int i = 0; i < 4; i++)
      m_pend[i] = rise[i] || (m_pend[i] && req[i] && i != pushed);
    for (int i = 0; i < 4; i++) m_prev[i] = req[i];
  endtask

  task automatic do_cycle(input logic [3:0] req, input logic rst);
    logic [3:0] exp_grant;
    req_drv = req;
    reset   = rst;
    @(posedge clock);
    model_step(req, rst);
    cyc++;
    #1;
    exp_grant = 4'b0000;
    if (m_phase == 1) exp_grant[3 - m_owner] = 1'b1;
    check_eq("grant",  {4'b0, grant_o},  {4'b0, exp_grant});
    check_eq("expire", {7'b0, expire_o}, {7'b0, m_expire});
    check_eq("qcount", {5'b0, qcount_o}, 8'(m_q.size()));
    check_eq("busy",   {7'b0, busy_o},   {7'b0, (m_phase != 0) || (m_q.size() > 0)});
  endtask

  task automatic hold(input logic [3:0] req, input int n);
    for (int i = 0; i < n; i++) do_cycle(req, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    req_drv = 4'b0000;
    reset   = 1'b1;
    // Reset with all requests high, then released.
    for (int i = 0; i < 3; i++) do_cycle(4'b1111, 1'b1);
    hold(4'b1111, 30);
    hold(4'b0000, 4);
    // Requester 1 held through expiry, then toggled for a fresh grant.
    hold(4'b0001, 12);
    hold(4'b0000, 1);
    hold(4'b0001, 10);
    hold(4'b0000, 4);
    // Requesters 2 and 4 together; 2 drops early.
    hold(4'b1010, 4);
    hold(4'b1000, 10);
    hold(4'b0000, 4);
    // Requester 3 first, requester 1 two edges later.
    hold(4'b0100, 2);
    hold(4'b0101, 14);
    hold(4'b0000, 4);
    // Requester 2 queued behind owner 4, then withdrawn before pop.
    hold(4'b1000, 3);
    hold(4'b1010, 2);
    hold(4'b1000, 2);
    hold(4'b0000, 6);
    // Reset mid-grant with entries queued, requests held.
    hold(4'b0111, 5);
    do_cycle(4'b0111, 1'b1);
    hold(4'b0111, 20);
    hold(4'b0000, 4);
    // Random toggling with occasional resets.
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      do_cycle(r, $urandom_range(0, 299) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
